// File: rtl/ifb_pkg.sv
// Shared types and helpers for the instruction fetch buffer.
// Holds the fetch entry layout and the credit check used to stall the PC.
package ifb_pkg;

  localparam int IFB_WIDTH   = 8;
  localparam int IFB_INSTR_W = 32;
  localparam int IFB_CNT_W   = 16;

  typedef struct packed {
    logic [IFB_WIDTH-1:0]   pc;
    logic [IFB_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Stall when buffered plus in-flight entries would use every slot.
  function automatic logic credit_stall(
    input int cnt,
    input int inflight,
    input int depth
  );
    return (cnt + inflight) >= depth;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO with flush, count output and registered storage.
// The head holds its last shown value while the FIFO is empty.
module ifb_fifo #(
  parameter  int DW    = 40,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] last_q;
  logic          do_push;
  logic          do_pop;
  logic          nonempty;

  assign nonempty = (count != '0);
  assign do_push  = push & ~flush;
  assign do_pop   = pop & nonempty & ~flush;
  assign head     = nonempty ? mem[rd_ptr] : last_q;

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Remember the last presented head so outputs hold when empty.
  always_ff @(posedge clk) begin
    if (rst) last_q <= '0;
    else if (nonempty) last_q <= mem[rd_ptr];
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(do_push && count == FULL)
  );

endmodule

// File: rtl/instr_fetch_buf.sv
// Fetch buffer: issues imem reads from the PC and queues {pc, instr}.
// Optional perf counters under IFB_PERF_CNT_EN (stall_cnt, flush_cnt).
module instr_fetch_buf
  import ifb_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int INSTR_W = IFB_INSTR_W,
  parameter  int DEPTH   = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc_in,
  input  logic               branch,
  output logic               pc_stall,
  output logic [WIDTH-1:0]   imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [WIDTH-1:0]   instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [IFB_CNT_W-1:0] stall_cnt,
  output logic [IFB_CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = WIDTH + INSTR_W;

  logic             req_vld;
  logic [WIDTH-1:0] req_pc;
  logic [CW-1:0]    count;
  logic [DW-1:0]    head;
  logic             push;
  logic             pop;

  assign imem_addr = pc_in;
  assign pc_stall  = credit_stall(int'(count), int'(req_vld), DEPTH);
  assign imem_req  = ~rst & ~branch & ~pc_stall;
  assign push      = req_vld & ~branch;
  assign pop       = instr_valid & instr_ready;

  assign instr_valid = (count != '0);
  assign instr_pc    = head[DW-1:INSTR_W];
  assign instr_out   = head[INSTR_W-1:0];

  // Track the single read in flight to the synchronous memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld <= 1'b0;
      req_pc  <= '0;
    end else if (imem_req) begin
      req_vld <= 1'b1;
      req_pc  <= pc_in;
    end else begin
      req_vld <= 1'b0;
    end
  end

  ifb_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch),
    .push      (push),
    .push_data ({req_pc, imem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef IFB_PERF_CNT_EN
  localparam int SW = IFB_CNT_W + 1;

  logic [SW-1:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt} + SW'(count) + SW'(req_vld);

  // Saturating count of cycles the PC is held.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (pc_stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Saturating count of entries discarded by branches.
  always_ff @(posedge clk) begin
    if (rst) flush_cnt <= '0;
    else if (branch)
      flush_cnt <= flush_sum[IFB_CNT_W] ? '1
                                        : flush_sum[IFB_CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Testbench for instr_fetch_buf: directed table, corner sequences,
// random traffic against a queue-based reference model.
module tb_instr_fetch_buf;
  import ifb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic        instr_ready;
  logic [7:0]  pc_in;
  logic [31:0] imem_rdata;
  logic        pc_stall;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [31:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
`ifdef IFB_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_buf #(.WIDTH(8), .INSTR_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .branch      (branch),
    .pc_stall    (pc_stall),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef IFB_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Synchronous instruction memory, one-cycle latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'hA500_0000 | {24'h0, imem_addr};
  end

  // Reference model state
  fetch_entry_t q[$];
  bit           inflight;
  logic [7:0]   inflight_pc;
  fetch_entry_t last;
  int           m_stall;
  int           m_flush;
  bit           model_chk;

  // Sampled outputs
  logic        s_valid, s_stall, s_req;
  logic [7:0]  s_pc, s_addr;
  logic [31:0] s_out;

  logic [7:0]  pc;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic b,
                      input logic [7:0] p, input logic rd);
    fetch_entry_t shown;
    bit e_valid, e_stall, e_req;
    int n;
    rst = r; branch = b; pc_in = p; instr_ready = rd;
    @(negedge clk);
    s_valid = instr_valid; s_stall = pc_stall; s_req = imem_req;
    s_pc = instr_pc; s_out = instr_out; s_addr = imem_addr;
    e_valid = q.size() != 0;
    shown   = e_valid ? q[0] : last;
    e_stall = (q.size() + int'(inflight)) >= 4;
    e_req   = !r && !b && !e_stall;
    if (model_chk) begin
      check("valid", 32'(s_valid), 32'(e_valid));
      check("instr_pc", 32'(s_pc), 32'(shown.pc));
      check("instr_out", s_out, shown.instr);
      check("pc_stall", 32'(s_stall), 32'(e_stall));
      check("imem_req", 32'(s_req), 32'(e_req));
      check("imem_addr", 32'(s_addr), 32'(p));
`ifdef IFB_PERF_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
    end
    if (r) begin
      q.delete(); inflight = 0; last = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_stall && m_stall < 16'hFFFF) m_stall++;
      last = shown;
      if (b) begin
        n = m_flush + q.size() + int'(inflight);
        m_flush = (n > 16'hFFFF) ? 16'hFFFF : n;
        q.delete(); inflight = 0;
      end else begin
        if (e_valid && rd) void'(q.pop_front());
        if (inflight)
          q.push_back('{pc: inflight_pc,
                        instr: 32'hA500_0000 | {24'h0, inflight_pc}});
        inflight = e_req; inflight_pc = p;
      end
    end
    @(posedge clk); #1;
  endtask

  // Stream with the bench acting as the PC
  task automatic run(input int n, input logic rd);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, pc, rd);
      if (s_stall) check("req_in_stall", 32'(s_req), 32'(0));
      else pc = pc + 8'd4;
    end
  endtask

  typedef struct {
    logic r, b; logic [7:0] p; logic rd; logic chk;
    logic v; logic [7:0] ipc; logic [31:0] iout; logic st, rq;
  } vec_t;
  vec_t tbl[8];

  initial begin
    model_chk = 0; inflight = 0; last = '0; m_stall = 0; m_flush = 0;
    rst = 1; branch = 0; pc_in = 0; instr_ready = 0;
    tbl[0] = '{1,0,8'h00,1,0, 0,8'h00,32'h0,0,0};
    tbl[1] = '{1,0,8'h00,1,1, 0,8'h00,32'h0,0,0};
    tbl[2] = '{0,0,8'h00,1,1, 0,8'h00,32'h0,0,1};
    tbl[3] = '{0,0,8'h04,1,1, 0,8'h00,32'h0,0,1};
    tbl[4] = '{0,0,8'h08,1,1, 1,8'h00,32'hA500_0000,0,1};
    tbl[5] = '{0,0,8'h0C,1,1, 1,8'h04,32'hA500_0004,0,1};
    tbl[6] = '{0,0,8'h10,1,1, 1,8'h08,32'hA500_0008,0,1};
    tbl[7] = '{0,0,8'h14,1,1, 1,8'h0C,32'hA500_000C,0,1};
    #1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].p, tbl[i].rd);
      model_chk = 1;
      if (tbl[i].chk) begin
        check("t_valid", 32'(s_valid), 32'(tbl[i].v));
        check("t_pc", 32'(s_pc), 32'(tbl[i].ipc));
        check("t_out", s_out, tbl[i].iout);
        check("t_stall", 32'(s_stall), 32'(tbl[i].st));
        check("t_req", 32'(s_req), 32'(tbl[i].rq));
      end
    end
    pc = 8'h18;

    // Backpressure then drain
    run(10, 1'b0);
    check("bp_stall", 32'(s_stall), 32'(1));
    run(8, 1'b1);

    // Branch with three buffered entries
    for (int i = 0; i < 12 && q.size() != 3; i++) run(1, 1'b0);
    step(1'b0, 1'b1, pc, 1'b1);
    pc = 8'h23;
    step(1'b0, 1'b0, pc, 1'b1);
    check("br_valid0", 32'(s_valid), 32'(0));
    pc = pc + 8'd4;
    run(1, 1'b1);
    step(1'b0, 1'b0, pc, 1'b1);
    check("br_pc", 32'(s_pc), 32'h23);
    check("br_out", s_out, 32'hA500_0023);
    pc = pc + 8'd4;
    run(4, 1'b1);

    // Reset with two entries and a request in flight
    for (int i = 0; i < 12 && !(q.size() == 2 && inflight); i++)
      run(1, 1'b0);
    step(1'b1, 1'b0, pc, 1'b0);
    pc = 8'h40;
    step(1'b0, 1'b0, pc, 1'b1);
    check("rst_valid0", 32'(s_valid), 32'(0));
    check("rst_out0", s_out, 32'h0);
    pc = pc + 8'd4;
    run(6, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, b, rd;
      r  = ($urandom_range(0, 59) == 0);
      b  = !r && ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 2) != 0);
      step(r, b, pc, rd);
      if (b) pc = 8'($urandom);
      else if (!r && !s_stall) pc = pc + 8'd4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
